// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART transmitter between NUM_REQ byte requesters.
//            Round-robin arbitration with packet locking: the owner keeps
//            the transmitter until it sends its last byte or reaches
//            MAX_BURST bytes. Each byte is handed over with a one-cycle
//            uart_tx_send. The arbiter then waits for uart_tx_done, and a
//            watchdog aborts the transfer if the transmitter is stuck.
// Ports    : clk_baud      - baud-rate clock, shared with the uart
//            rst           - synchronous reset, active-high
//            req_valid     - per-requester byte valid
//            req_data      - per-requester byte, slice i at [8i+7:8i]
//            req_last      - per-requester end-of-packet marker
//            req_ready     - combinational accept, owner only, in LOAD
//            grant_id      - current owner index (valid while busy)
//            busy          - lock held (state != IDLE)
//            uart_tx_byte  - registered byte to the transmitter
//            uart_tx_send  - registered one-cycle send strobe
//            uart_tx_done  - one-cycle completion pulse from transmitter
//            timeout_err   - one-cycle pulse on watchdog abort
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk_baud,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic [7:0]           uart_tx_byte,
  output logic                 uart_tx_send,
  input  logic                 uart_tx_done,
  output logic                 timeout_err
);

  // Watchdog counter only needs to reach TIMEOUT-1.
  localparam int                c_WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST   = c_WD_W'(TIMEOUT - 1);
  localparam logic [7:0]        c_BURST_MAX = 8'(MAX_BURST);
  localparam logic [2:0]        c_LAST_ID   = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [2:0]          r_rr_ptr;
  logic [2:0]          r_grant_id;
  logic [7:0]          r_burst_cnt;
  logic [c_WD_W-1:0]   r_wd_cnt;
  logic                r_last_flag;
  logic [7:0]          r_tx_byte;
  logic                r_tx_send;
  logic                r_timeout_err;

  logic [2*NUM_REQ-1:0] w_rot_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [2:0]           w_off;
  logic [3:0]           w_sum;
  logic [2:0]           w_sel_id;
  logic                 w_sel_valid;
  logic                 w_own_valid;
  logic                 w_own_last;
  logic [7:0]           w_own_data;
  logic [2:0]           w_next_ptr;

  // Rotate the valid vector so bit 0 corresponds to rr_ptr; the lowest set
  // bit of the rotated vector is then the round-robin winner's offset.
  assign w_rot_dbl   = {req_valid, req_valid} >> r_rr_ptr;
  assign w_rot       = w_rot_dbl[NUM_REQ-1:0];
  assign w_sel_valid = |w_rot;

  always_comb begin
    w_off = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = 3'(i);
      end
    end
  end

  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_sel_id = (w_sum >= 4'(NUM_REQ)) ? 3'(w_sum - 4'(NUM_REQ)) : w_sum[2:0];

  // Owner's request fields.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == 3'(i)) begin
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
        w_own_data  = req_data[8*i +: 8];
      end
    end
  end

  // Ready is suppressed during reset so no byte is consumed in that cycle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = !rst && (r_state == ST_LOAD) && (r_grant_id == 3'(i));
    end
  end

  assign w_next_ptr = (r_grant_id == c_LAST_ID) ? 3'd0 : r_grant_id + 3'd1;

  always_ff @(posedge clk_baud) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= 3'd0;
      r_grant_id    <= 3'd0;
      r_burst_cnt   <= 8'd0;
      r_wd_cnt      <= '0;
      r_last_flag   <= 1'b0;
      r_tx_byte     <= 8'h00;
      r_tx_send     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_send     <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sel_valid) begin
            r_grant_id  <= w_sel_id;
            r_burst_cnt <= 8'd0;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_own_valid) begin
            r_tx_byte   <= w_own_data;
            r_tx_send   <= 1'b1;
            r_last_flag <= w_own_last;
            r_burst_cnt <= r_burst_cnt + 8'd1;
            r_wd_cnt    <= '0;
            r_state     <= ST_WAIT;
          end else begin
            // Owner withdrew mid-packet: give the transmitter away.
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          // Done takes priority over a coincident watchdog expiry.
          if (uart_tx_done) begin
            if (r_last_flag || (r_burst_cnt == c_BURST_MAX)) begin
              r_rr_ptr <= w_next_ptr;
              r_state  <= ST_IDLE;
            end else begin
              r_state <= ST_LOAD;
            end
          end else if (r_wd_cnt == c_WD_LAST) begin
            r_timeout_err <= 1'b1;
            r_rr_ptr      <= w_next_ptr;
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_id     = r_grant_id;
  assign busy         = (r_state != ST_IDLE);
  assign uart_tx_byte = r_tx_byte;
  assign uart_tx_send = r_tx_send;
  assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. Two instances share
//            all inputs: dut_a uses default parameters, dut_b uses
//            MAX_BURST=2. Per-requester byte queues feed the inputs, a
//            transmitter model answers uart_tx_send with uart_tx_done, and a
//            scoreboard of {grant_id, byte} is checked on every send.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int TIMEOUT  = 32;
  localparam int TX_DELAY = 3;

  logic                 clk_baud;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic                 uart_tx_done;

  logic [NUM_REQ-1:0] ready_a, ready_b;
  logic [2:0]         grant_a, grant_b;
  logic               busy_a, busy_b;
  logic [7:0]         byte_a, byte_b;
  logic               send_a, send_b;
  logic               terr_a, terr_b;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .MAX_BURST(16)) dut_a (
    .clk_baud(clk_baud), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_a), .grant_id(grant_a), .busy(busy_a),
    .uart_tx_byte(byte_a), .uart_tx_send(send_a), .uart_tx_done(uart_tx_done),
    .timeout_err(terr_a));

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .MAX_BURST(2)) dut_b (
    .clk_baud(clk_baud), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_b), .grant_id(grant_b), .busy(busy_b),
    .uart_tx_byte(byte_b), .uart_tx_send(send_b), .uart_tx_done(uart_tx_done),
    .timeout_err(terr_b));

  // Instance under observation.
  logic               sel_b;
  logic [NUM_REQ-1:0] s_ready;
  logic [2:0]         s_grant;
  logic               s_busy, s_send, s_terr;
  logic [7:0]         s_byte;
  assign s_ready = sel_b ? ready_b : ready_a;
  assign s_grant = sel_b ? grant_b : grant_a;
  assign s_busy  = sel_b ? busy_b  : busy_a;
  assign s_send  = sel_b ? send_b  : send_a;
  assign s_terr  = sel_b ? terr_b  : terr_a;
  assign s_byte  = sel_b ? byte_b  : byte_a;

  int vectors;
  int miscompares;
  int send_count;
  bit model_en;
  bit done_en;

  logic [8:0]  rq [NUM_REQ][$];   // {last, data} per requester
  logic [10:0] sb [$];            // expected {grant_id, byte}

  initial begin
    clk_baud = 1'b0;
    forever #5 clk_baud = ~clk_baud;
  end

  // Requester model: presents queue heads, pops after an accepting edge.
  initial begin
    logic [NUM_REQ-1:0] fire;
    logic [8:0]         e;
    fire = '0;
    forever begin
      @(negedge clk_baud);
      if (model_en) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (rq[i].size() > 0) begin
            e = rq[i][0];
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = e[7:0];
            req_last[i]        = e[8];
          end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
          end
        end
        #1;
        fire = req_valid & s_ready;
      end else begin
        fire = '0;
      end
    end
  end

  // Transmitter model: done pulse TX_DELAY cycles after send.
  initial begin
    uart_tx_done = 1'b0;
    forever begin
      @(negedge clk_baud);
      if (s_send && done_en) begin
        repeat (TX_DELAY - 1) @(negedge clk_baud);
        uart_tx_done = 1'b1;
        @(negedge clk_baud);
        uart_tx_done = 1'b0;
      end
    end
  end

  // Scoreboard: every send must match the oldest expected {owner, byte}.
  initial begin
    logic [10:0] exp_e;
    forever begin
      @(negedge clk_baud);
      if (s_send === 1'b1) begin
        send_count++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: got id %0d byte %h, want no send", s_grant, s_byte);
        end else begin
          exp_e = sb.pop_front();
          if ({s_grant, s_byte} !== exp_e) begin
            miscompares++;
            $display("FAIL sb_send: got id %0d byte %h, want id %0d byte %h",
                     s_grant, s_byte, exp_e[10:8], exp_e[7:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_baud);
    #1;
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    tick();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (sb.size() == 0 && !s_busy && rq_empty() && !uart_tx_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    vectors++;
    if ({ready_a, grant_a, busy_a, byte_a, send_a, terr_a} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_a: got %h, want 0", {ready_a, grant_a, busy_a, byte_a, send_a, terr_a});
    end
    vectors++;
    if ({ready_b, grant_b, busy_b, byte_b, send_b, terr_b} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_b: got %h, want 0", {ready_b, grant_b, busy_b, byte_b, send_b, terr_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int ready_cnt, rdy_cyc, snd_cyc, done_cyc;
    bit ok;
    do_reset();
    rq[0].push_back({1'b1, 8'hA5});
    sb.push_back({3'd0, 8'hA5});
    ready_cnt = 0; rdy_cyc = -1; snd_cyc = -1; done_cyc = -1;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      tick();
      if (s_ready[0]) begin
        ready_cnt++;
        if (rdy_cyc < 0) rdy_cyc = c;
      end
      if (s_send && snd_cyc < 0) snd_cyc = c;
      if (uart_tx_done) done_cyc = c;
    end
    vectors++;
    if (ready_cnt != 1) begin
      miscompares++;
      $display("FAIL single_ready_cycles: got %0d, want 1", ready_cnt);
    end
    vectors++;
    if (rdy_cyc < 0 || snd_cyc != rdy_cyc + 1) begin
      miscompares++;
      $display("FAIL single_send_latency: got send at %0d ready at %0d, want send one after ready", snd_cyc, rdy_cyc);
    end
    tick();
    vectors++;
    if (s_busy !== 1'b0 || done_cyc < 0) begin
      miscompares++;
      $display("FAIL single_release: got busy %b done_cyc %0d, want busy 0 after done", s_busy, done_cyc);
    end
    // Pointer now sits at 1, so requester 1 wins over 0.
    rq[0].push_back({1'b1, 8'hB0});
    rq[1].push_back({1'b1, 8'hB1});
    sb.push_back({3'd1, 8'hB1});
    sb.push_back({3'd0, 8'hB0});
    wait_idle(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_rr_timeout: got not idle, want idle within 200 cycles");
    end
  endtask

  task automatic test_contention();
    int base;
    bit ok;
    do_reset();
    base = send_count;
    rq[0].push_back({1'b1, 8'h40});
    rq[0].push_back({1'b1, 8'h44});
    for (int i = 1; i < NUM_REQ; i++) rq[i].push_back({1'b1, 8'(8'h40 + i)});
    sb.push_back({3'd0, 8'h40});
    sb.push_back({3'd1, 8'h41});
    sb.push_back({3'd2, 8'h42});
    sb.push_back({3'd3, 8'h43});
    sb.push_back({3'd0, 8'h44});
    wait_idle(300, ok);
    vectors++;
    if (!ok || send_count - base != 5) begin
      miscompares++;
      $display("FAIL contention_sends: got %0d sends idle=%b, want 5 and idle", send_count - base, ok);
    end
  endtask

  task automatic test_packet_lock();
    int base, r1_early, r0_cnt;
    bit ok;
    do_reset();
    base = send_count;
    r1_early = 0; r0_cnt = 0; ok = 1'b0;
    rq[0].push_back({1'b0, 8'h11});
    rq[0].push_back({1'b0, 8'h22});
    rq[0].push_back({1'b1, 8'h33});
    rq[1].push_back({1'b1, 8'h55});
    sb.push_back({3'd0, 8'h11});
    sb.push_back({3'd0, 8'h22});
    sb.push_back({3'd0, 8'h33});
    sb.push_back({3'd1, 8'h55});
    for (int c = 0; c < 300; c++) begin
      tick();
      if (s_ready[1] && (send_count - base) < 3) r1_early++;
      if (s_ready[0]) r0_cnt++;
      if (sb.size() == 0 && !s_busy && rq_empty() && !uart_tx_done) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL lock_timeout: got not idle, want idle within 300 cycles");
    end
    vectors++;
    if (r1_early != 0) begin
      miscompares++;
      $display("FAIL lock_ready1_early: got %0d cycles, want 0", r1_early);
    end
    vectors++;
    if (r0_cnt != 3) begin
      miscompares++;
      $display("FAIL lock_ready0_cycles: got %0d, want 3", r0_cnt);
    end
  endtask

  task automatic test_burst_limit();
    int base;
    bit ok;
    sel_b = 1'b1;
    do_reset();
    base = send_count;
    rq[0].push_back({1'b0, 8'hA1});
    rq[0].push_back({1'b0, 8'hA2});
    rq[0].push_back({1'b0, 8'hA3});
    rq[0].push_back({1'b1, 8'hA4});
    rq[1].push_back({1'b1, 8'hB1});
    sb.push_back({3'd0, 8'hA1});
    sb.push_back({3'd0, 8'hA2});
    sb.push_back({3'd1, 8'hB1});
    sb.push_back({3'd0, 8'hA3});
    sb.push_back({3'd0, 8'hA4});
    wait_idle(300, ok);
    vectors++;
    if (!ok || send_count - base != 5) begin
      miscompares++;
      $display("FAIL burst_sends: got %0d sends idle=%b, want 5 and idle", send_count - base, ok);
    end
    sel_b = 1'b0;
  endtask

  task automatic test_watchdog();
    int s_cyc, t_cyc, terr_n;
    logic busy_at_t, busy_after, terr_after;
    logic [2:0] grant_after;
    bit ok;
    do_reset();
    done_en = 1'b0;
    rq[0].push_back({1'b1, 8'h5A});
    rq[1].push_back({1'b1, 8'h5B});
    sb.push_back({3'd0, 8'h5A});
    sb.push_back({3'd1, 8'h5B});
    s_cyc = -1; t_cyc = -1; terr_n = 0;
    busy_at_t = 1'bx; busy_after = 1'bx; terr_after = 1'bx; grant_after = 3'bx;
    for (int c = 0; c < 200 && terr_n < 2; c++) begin
      tick();
      if (t_cyc >= 0 && c == t_cyc + 1) begin
        busy_after  = s_busy;
        grant_after = s_grant;
        terr_after  = s_terr;
      end
      if (s_send && s_cyc < 0) s_cyc = c;
      if (s_terr) begin
        terr_n++;
        if (t_cyc < 0) begin
          t_cyc     = c;
          busy_at_t = s_busy;
        end
      end
    end
    vectors++;
    if (s_cyc < 0 || t_cyc - s_cyc != TIMEOUT) begin
      miscompares++;
      $display("FAIL wd_latency: got %0d cycles, want %0d", t_cyc - s_cyc, TIMEOUT);
    end
    vectors++;
    if (busy_at_t !== 1'b0 || terr_after !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_release: got busy %b next_terr %b, want 0 0", busy_at_t, terr_after);
    end
    vectors++;
    if (busy_after !== 1'b1 || grant_after !== 3'd1) begin
      miscompares++;
      $display("FAIL wd_next_grant: got busy %b id %0d, want busy 1 id 1", busy_after, grant_after);
    end
    vectors++;
    if (terr_n != 2) begin
      miscompares++;
      $display("FAIL wd_pulses: got %0d, want 2", terr_n);
    end
    wait_idle(100, ok);
    done_en = 1'b1;
  endtask

  task automatic test_reset_abandon();
    int base;
    bit ok;
    // Reset while waiting on the transmitter.
    do_reset();
    done_en = 1'b0;
    base = send_count;
    rq[2].push_back({1'b1, 8'h77});
    sb.push_back({3'd2, 8'h77});
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (send_count != base) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (!ok || {s_ready, s_grant, s_busy, s_byte, s_send, s_terr} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_in_wait: got %h sent=%b, want 0 and sent", {s_ready, s_grant, s_busy, s_byte, s_send, s_terr}, ok);
    end
    rst = 1'b0;
    done_en = 1'b1;

    // Owner withdraws in LOAD.
    model_en = 1'b0;
    tick();
    base = send_count;
    req_valid = 4'b0001;
    req_data  = {8'h00, 8'h00, 8'h98, 8'h99};
    req_last  = 4'b0011;
    tick();
    vectors++;
    if ({s_busy, s_ready} !== 5'b1_0001) begin
      miscompares++;
      $display("FAIL abandon_load: got %b, want 10001", {s_busy, s_ready});
    end
    req_valid = 4'b0000;
    tick();
    vectors++;
    if ({s_busy, s_ready} !== 5'b0_0000 || send_count != base) begin
      miscompares++;
      $display("FAIL abandon_release: got %b sends %0d, want 00000 and no send", {s_busy, s_ready}, send_count - base);
    end
    req_valid = 4'b0011;
    tick();
    vectors++;
    if (s_busy !== 1'b1 || s_grant !== 3'd1) begin
      miscompares++;
      $display("FAIL abandon_next: got busy %b id %0d, want busy 1 id 1", s_busy, s_grant);
    end
    // Reset asserted while in LOAD must mask ready immediately.
    rst = 1'b1;
    #1;
    vectors++;
    if (s_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ready_mask: got %b, want 0000", s_ready);
    end
    tick();
    vectors++;
    if (s_busy !== 1'b0 || s_grant !== 3'd0 || send_count != base) begin
      miscompares++;
      $display("FAIL reset_in_load: got busy %b id %0d, want busy 0 id 0", s_busy, s_grant);
    end
    rst = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    req_data  = '0;
    model_en  = 1'b1;
    tick();
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    sel_b        = 1'b0;
    model_en     = 1'b1;
    done_en      = 1'b1;
    vectors      = 0;
    miscompares  = 0;
    send_count   = 0;
    test_reset();
    test_single();
    test_contention();
    test_packet_lock();
    test_burst_limit();
    test_watchdog();
    test_reset_abandon();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200000");
    $fatal(1, "global time limit");
  end

endmodule
`default_nettype wire
